mem_key_tdr: RTL and testbench

- Key-delivery test data register that sits directly upstream of the memory-compare locking SIB.
- Receives a Length-bit key serially over the IJTAG scan path and presents it in parallel on KBits to the downstream comparator.
- Samples the comparator's match result one cycle after each update and counts failed attempts.
- Enters a sticky lockout state after MaxTries failures; lockout forces KBits to zero until reset.
- Capture never returns key bits, so the shifted key cannot be read back out of the chain.

---
 rtl/mem_key_tdr.sv | 113 +++++++++++
 tb/tb_mem_key_tdr.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_key_tdr.sv
// Key-delivery test data register: serial key in over the scan path, parallel key out to the comparator.
// Counts failed unlock attempts and latches a sticky lockout that forces the key to zero.
module mem_key_tdr #(
    parameter int Length   = 256,
    parameter int MaxTries = 3,
    parameter int CntW     = 4
) (
    input  logic              Clock,
    input  logic              RstBar,
    input  logic              SI,
    input  logic              ShiftEN,
    input  logic              CaptureEN,
    input  logic              UpdateEn,
    input  logic              Select,
    input  logic              Unlocked,
    output logic              SO,
    output logic [Length-1:0] KBits,
    output logic              Locked,
    output logic [CntW-1:0]   FailCnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EVAL    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    localparam logic [CntW:0] MAX_TRIES = (CntW + 1)'(MaxTries);

    state_t              state;
    state_t              state_nxt;
    logic [Length-1:0]   shift_q;
    logic [Length-1:0]   capture_word;
    logic [CntW-1:0]     fail_cnt_nxt;
    logic [CntW:0]       fail_inc;
    logic                do_capture;
    logic                do_shift;
    logic                do_update;

    // Enables are mutually exclusive by priority: capture, then shift, then update.
    assign do_capture = Select & CaptureEN;
    assign do_shift   = Select & ~CaptureEN & ShiftEN;
    assign do_update  = Select & ~CaptureEN & ~ShiftEN & UpdateEn & (state == IDLE);

    assign fail_inc = {1'b0, FailCnt} + (CntW + 1)'(1);

    // Status only; key bits are never loaded back so the key cannot be scanned out.
    always_comb begin
        capture_word             = '0;
        capture_word[CntW+1:0]   = {FailCnt, Locked, Unlocked};
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        fail_cnt_nxt = FailCnt;
        case (state)
            IDLE: begin
                if (do_update) state_nxt = EVAL;
            end
            EVAL: begin
                if (Unlocked) begin
                    fail_cnt_nxt = '0;
                    state_nxt    = IDLE;
                end else if (fail_inc < MAX_TRIES) begin
                    fail_cnt_nxt = fail_inc[CntW-1:0];
                    state_nxt    = IDLE;
                end else begin
                    fail_cnt_nxt = MAX_TRIES[CntW-1:0];
                    state_nxt    = LOCKOUT;
                end
            end
            LOCKOUT: state_nxt = LOCKOUT;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge Clock or negedge RstBar) begin
        if (!RstBar) begin
            state   <= IDLE;
            FailCnt <= '0;
        end else begin
            state   <= state_nxt;
            FailCnt <= fail_cnt_nxt;
        end
    end

    always_ff @(posedge Clock or negedge RstBar) begin
        if (!RstBar) begin
            shift_q <= '0;
        end else if (do_capture) begin
            shift_q <= capture_word;
        end else if (do_shift) begin
            shift_q <= {SI, shift_q[Length-1:1]};
        end
    end

    // Entering lockout wipes the key; no update is accepted afterwards, so it stays zero.
    always_ff @(posedge Clock or negedge RstBar) begin
        if (!RstBar) begin
            KBits <= '0;
        end else if (state == EVAL && state_nxt == LOCKOUT) begin
            KBits <= '0;
        end else if (do_update) begin
            KBits <= shift_q;
        end
    end

    assign SO     = shift_q[0];
    assign Locked = (state == LOCKOUT);

endmodule

// File: tb/tb_mem_key_tdr.sv
// Self-checking bench for mem_key_tdr: directed scenarios plus randomized enables,
// compared every cycle against a behavioural model of the key register.
module tb_mem_key_tdr;

    localparam int LEN  = 256;
    localparam int MAXT = 3;
    localparam int CW   = 4;
    localparam logic [LEN-1:0] SECRET = LEN'(3412345);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           si = 1'b0;
    logic           shen = 1'b0;
    logic           cap = 1'b0;
    logic           upd = 1'b0;
    logic           sel = 1'b0;
    logic           unlocked;
    logic           so;
    logic [LEN-1:0] kbits;
    logic           locked;
    logic [CW-1:0]  fail_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model
    logic [LEN-1:0] m_shift;
    logic [LEN-1:0] m_kbits;
    int             m_fail;
    bit             m_locked;
    bit             m_eval;

    mem_key_tdr #(.Length(LEN), .MaxTries(MAXT), .CntW(CW)) dut (
        .Clock     (clk),
        .RstBar    (rst_n),
        .SI        (si),
        .ShiftEN   (shen),
        .CaptureEN (cap),
        .UpdateEn  (upd),
        .Select    (sel),
        .Unlocked  (unlocked),
        .SO        (so),
        .KBits     (kbits),
        .Locked    (locked),
        .FailCnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    // Downstream comparator stand-in.
    assign unlocked = (kbits == SECRET);

    task automatic check(input string tag, input logic [LEN-1:0] got, input logic [LEN-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_shift  = '0;
        m_kbits  = '0;
        m_fail   = 0;
        m_locked = 0;
        m_eval   = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".so"},     LEN'(so),       LEN'(m_shift[0]));
        check({tag, ".kbits"},  kbits,          m_kbits);
        check({tag, ".locked"}, LEN'(locked),   LEN'(m_locked));
        check({tag, ".fail"},   LEN'(fail_cnt), LEN'(m_fail));
    endtask

    // Advance one clock with the currently driven inputs, update the model, compare.
    task automatic tick(input string tag);
        bit             unl;
        logic [LEN-1:0] sh;
        int             f;
        bit             lk;
        bit             ev;
        unl = (m_kbits == SECRET);
        sh  = m_shift;
        f   = m_fail;
        lk  = m_locked;
        ev  = m_eval;
        if (sel) begin
            if (cap)
                m_shift = LEN'(f * 4 + int'(lk) * 2 + int'(unl));
            else if (shen)
                m_shift = (sh >> 1) | (LEN'(si) << (LEN - 1));
            else if (upd && !ev && !lk) begin
                m_kbits = sh;
                m_eval  = 1;
            end
        end
        if (ev) begin
            m_eval = 0;
            if (unl)
                m_fail = 0;
            else if (f + 1 < MAXT)
                m_fail = f + 1;
            else begin
                m_fail   = MAXT;
                m_locked = 1;
                m_kbits  = '0;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        sel  = 1'b1;
        shen = 1'b0;
        cap  = 1'b0;
        upd  = 1'b0;
        si   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_outputs("reset");
        rst_n = 1'b1;
    endtask

    task automatic shift_key(input logic [LEN-1:0] key);
        logic [LEN-1:0] k;
        k = key;
        idle_inputs();
        shen = 1'b1;
        for (int i = 0; i < LEN; i++) begin
            si = k[i];
            tick("shift");
        end
        idle_inputs();
    endtask

    // Shift a key, pulse update (KBits valid after it), then let EVAL complete.
    task automatic update_key(input logic [LEN-1:0] key);
        shift_key(key);
        upd = 1'b1;
        tick("update");
        upd = 1'b0;
        tick("eval");
    endtask

    initial begin
        logic [7:0] status;
        model_reset();
        idle_inputs();
        #3;
        check_outputs("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-shift with nonzero data in the chain.
        shen = 1'b1;
        si   = 1'b1;
        for (int i = 0; i < LEN + 10; i++) tick("fill");
        check("fill_so", LEN'(so), LEN'(1));
        do_reset();
        check("rst_so", LEN'(so), '0);
        idle_inputs();

        // Correct key.
        shift_key(SECRET);
        upd = 1'b1;
        tick("ok_upd");
        upd = 1'b0;
        check("ok_kbits", kbits, SECRET);
        tick("ok_eval");
        check("ok_fail", LEN'(fail_cnt), '0);
        check("ok_locked", LEN'(locked), '0);

        // Update with Select low is dropped.
        sel = 1'b0;
        upd = 1'b1;
        tick("nosel_upd");
        check("nosel_kbits", kbits, SECRET);
        idle_inputs();
        tick("nosel_idle");

        // Status capture after one wrong key.
        do_reset();
        update_key(LEN'(5));
        check("cap_fail", LEN'(fail_cnt), LEN'(1));
        cap = 1'b1;
        tick("cap");
        cap  = 1'b0;
        shen = 1'b1;
        for (int i = 0; i < 8; i++) begin
            status[i] = so;
            si        = 1'b0;
            tick("cap_shift");
        end
        idle_inputs();
        check("cap_status", LEN'(status), LEN'(8'h04));

        // Capture beats shift when both are asserted.
        cap  = 1'b1;
        shen = 1'b1;
        si   = 1'b1;
        tick("prio");
        idle_inputs();

        // Recovery: two wrong keys then the correct one.
        do_reset();
        update_key(LEN'(7));
        check("rec_f1", LEN'(fail_cnt), LEN'(1));
        update_key(LEN'(8));
        check("rec_f2", LEN'(fail_cnt), LEN'(2));
        update_key(SECRET);
        check("rec_f0", LEN'(fail_cnt), '0);
        check("rec_locked", LEN'(locked), '0);

        // Lockout after three failures; later correct key is ignored.
        do_reset();
        update_key(LEN'(0));
        check("lk_f1", LEN'(fail_cnt), LEN'(1));
        update_key(LEN'(1));
        check("lk_f2", LEN'(fail_cnt), LEN'(2));
        update_key(LEN'(2));
        check("lk_f3", LEN'(fail_cnt), LEN'(3));
        check("lk_locked", LEN'(locked), LEN'(1));
        check("lk_kbits", kbits, '0);
        update_key(SECRET);
        check("lk_kbits_hold", kbits, '0);
        check("lk_still", LEN'(locked), LEN'(1));

        // Randomized enables, with occasional correct keys and resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 350) begin
                update_key(SECRET);
            end else if (c % 900 == 899) begin
                do_reset();
            end else begin
                sel  = m_eval ? 1'b1 : (($urandom % 8) != 0);
                cap  = (($urandom % 16) == 0);
                shen = (($urandom % 2) == 0);
                upd  = (($urandom % 6) == 0);
                si   = 1'($urandom);
                tick("rand");
            end
        end
        idle_inputs();
        tick("end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
